// File: rtl/lb_uart_tx.sv
// 8N1 UART transmitter with a runtime prescaler and a fixed 16-tick bit time.
// Outputs are registered; a request is accepted only in IDLE while cs is high.
module lb_uart_tx #(
    parameter int PRESCALE_W    = 20,
    parameter int TICKS_PER_BIT = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cs,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  start,
    input  logic [7:0]            data_in,
    output logic                  tx,
    output logic                  busy,
    output logic                  done
);

    localparam int TICK_W = $clog2(TICKS_PER_BIT);
    localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(TICKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t                state, state_n;
    logic [PRESCALE_W-1:0] pcnt, pcnt_n;
    logic [PRESCALE_W-1:0] p_q, p_n;
    logic [TICK_W-1:0]     tcnt, tcnt_n;
    logic [2:0]            bidx, bidx_n;
    logic [7:0]            shreg, shreg_n;
    logic                  tx_q, tx_n;
    logic                  busy_q, busy_n;
    logic                  done_q, done_n;
    logic                  tick;
    logic                  bit_end;

    // Equality compare against the latched period, so P = all ones never overflows.
    assign tick    = (pcnt == p_q);
    assign bit_end = tick && (tcnt == LAST_TICK);

    // NOTE: every variable gets a default before the case statement, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_n = state;
        pcnt_n  = pcnt;
        p_n     = p_q;
        tcnt_n  = tcnt;
        bidx_n  = bidx;
        shreg_n = shreg;
        tx_n    = tx_q;
        busy_n  = busy_q;
        done_n  = 1'b0;

        if (state != IDLE) begin
            pcnt_n = tick ? '0 : pcnt + PRESCALE_W'(1);
            if (tick) begin
                tcnt_n = tcnt + TICK_W'(1);
            end
        end

        case (state)
            IDLE: begin
                tx_n   = 1'b1;
                busy_n = 1'b0;
                if (start && cs) begin
                    shreg_n = data_in;
                    p_n     = prescale;
                    pcnt_n  = '0;
                    tcnt_n  = '0;
                    bidx_n  = '0;
                    tx_n    = 1'b0;
                    busy_n  = 1'b1;
                    state_n = START;
                end
            end
            START: begin
                if (bit_end) begin
                    bidx_n  = '0;
                    tx_n    = shreg[0];
                    state_n = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bidx == 3'd7) begin
                        tx_n    = 1'b1;
                        state_n = STOP;
                    end else begin
                        bidx_n = bidx + 3'd1;
                        tx_n   = shreg[bidx + 3'd1];
                    end
                end
            end
            STOP: begin
                // Leaving STOP lands in IDLE with done high for exactly this cycle.
                if (bit_end) begin
                    tx_n    = 1'b1;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values computed above.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            pcnt   <= '0;
            p_q    <= '0;
            tcnt   <= '0;
            bidx   <= '0;
            shreg  <= '0;
            tx_q   <= 1'b1;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            pcnt   <= pcnt_n;
            p_q    <= p_n;
            tcnt   <= tcnt_n;
            bidx   <= bidx_n;
            shreg  <= shreg_n;
            tx_q   <= tx_n;
            busy_q <= busy_n;
            done_q <= done_n;
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_lb_uart_tx.sv
// Scoreboard bench for lb_uart_tx: stimulus queues expected frames, a monitor
// decodes the serial line cycle by cycle and checks timing, data and done.
module tb_lb_uart_tx;

    localparam int PW = 20;

    logic          clk = 1'b0;
    logic          reset;
    logic          cs;
    logic          start;
    logic [PW-1:0] prescale;
    logic [7:0]    data_in;
    logic          tx;
    logic          busy;
    logic          done;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] data;
        int         bitlen;
        int         start_cyc;
        int         abort_off;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    bit   mon_en     = 1'b0;
    bit   mon_active = 1'b0;

    lb_uart_tx #(.PRESCALE_W(PW), .TICKS_PER_BIT(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .cs       (cs),
        .prescale (prescale),
        .start    (start),
        .data_in  (data_in),
        .tx       (tx),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // cyc equals the index of the most recent rising edge when read at a negedge.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic summary_and_finish();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    // Drive one request for a single clock; the accepting edge is the next one.
    task automatic start_frame(input logic [7:0] d, input int p, input int abort_off,
                               output int k);
        exp_t e;
        prescale    = PW'(p);
        data_in     = d;
        cs          = 1'b1;
        start       = 1'b1;
        k           = cyc + 1;
        e.data      = d;
        e.bitlen    = 16 * (p + 1);
        e.start_cyc = k;
        e.abort_off = abort_off;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || mon_active) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("frames_drained_in_budget", 32'(n < budget), 32'd1);
        if (n >= budget) summary_and_finish();
    endtask

    // Checks one frame starting at the current negedge (first cycle with tx low).
    task automatic run_frame(input exp_t e);
        int         l;
        int         good;
        int         b;
        logic       expb;
        logic [7:0] got;
        l    = e.bitlen;
        good = 0;
        got  = 8'h00;
        check($sformatf("frame_%02h_start_cycle", e.data), 32'(cyc), 32'(e.start_cyc));
        for (int off = 0; off < 10 * l; off++) begin
            if (off > 0) @(negedge clk);
            if (off == e.abort_off) begin
                check($sformatf("frame_%02h_abort_done_busy_tx", e.data),
                      {29'd0, done, busy, tx}, 32'b001);
                return;
            end
            b = off / l;
            if (b == 0)      expb = 1'b0;
            else if (b == 9) expb = 1'b1;
            else             expb = e.data[b-1];
            if (tx === expb && busy === 1'b1 && done === 1'b0) good++;
            if ((off % l) == (l / 2) && b >= 1 && b <= 8) got[b-1] = tx;
            if ((off % l) == l - 1) begin
                check($sformatf("frame_%02h_bit%0d_good_cycles", e.data, b), 32'(good), 32'(l));
                good = 0;
            end
        end
        check($sformatf("frame_%02h_byte", e.data), {24'd0, got}, {24'd0, e.data});
        @(negedge clk);
        check($sformatf("frame_%02h_done_busy_tx", e.data), {29'd0, done, busy, tx}, 32'b101);
    endtask

    // Monitor: outside a frame the line must be idle; a falling tx pops the next expectation.
    initial begin
        wait (mon_en);
        forever begin
            @(negedge clk);
            if (tx === 1'b0 && exp_q.size() > 0) begin
                mon_active = 1'b1;
                mon_e      = exp_q.pop_front();
                run_frame(mon_e);
                mon_active = 1'b0;
            end else begin
                check("idle_done_busy_tx", {29'd0, done, busy, tx}, 32'b001);
            end
        end
    end

    initial begin
        int k;
        int k2;
        reset    = 1'b1;
        cs       = 1'b0;
        start    = 1'b0;
        prescale = '0;
        data_in  = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_tx", {31'd0, tx}, 32'd1);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_done_busy_tx", {29'd0, done, busy, tx}, 32'b001);
        mon_en = 1'b1;

        // Basic frame, fastest prescale.
        start_frame(8'hA5, 0, -1, k);
        wait_idle(400);
        repeat (5) @(negedge clk);

        // Slower bit timing: 64 cycles per bit.
        start_frame(8'h00, 3, -1, k);
        wait_idle(1000);
        repeat (5) @(negedge clk);

        // start held with cs low must never launch a frame.
        cs      = 1'b0;
        start   = 1'b1;
        data_in = 8'hFF;
        repeat (100) @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);

        // A second request mid-frame is dropped; no follow-on frame appears.
        start_frame(8'h5A, 0, -1, k);
        wait_cyc(k + 40);
        cs      = 1'b1;
        start   = 1'b1;
        data_in = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        wait_idle(400);
        repeat (20) @(negedge clk);

        // Back-to-back with start held: second acceptance at the done cycle.
        begin
            exp_t e1;
            exp_t e2;
            prescale     = '0;
            data_in      = 8'h55;
            cs           = 1'b1;
            start        = 1'b1;
            k            = cyc + 1;
            e1.data      = 8'h55;
            e1.bitlen    = 16;
            e1.start_cyc = k;
            e1.abort_off = -1;
            e2.data      = 8'hAA;
            e2.bitlen    = 16;
            e2.start_cyc = k + 161;
            e2.abort_off = -1;
            exp_q.push_back(e1);
            exp_q.push_back(e2);
            @(negedge clk);
            data_in = 8'hAA;
            wait_cyc(k + 161);
            start = 1'b0;
            wait_idle(600);
            repeat (5) @(negedge clk);
        end

        // Reset pulse during D3 aborts; a request right after reset is accepted.
        start_frame(8'h3C, 0, 69, k);
        wait_cyc(k + 68);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start_frame(8'hC3, 1, -1, k2);
        wait_idle(800);
        repeat (5) @(negedge clk);

        // prescale and data_in changes mid-frame leave the frame untouched.
        start_frame(8'h96, 1, -1, k);
        wait_cyc(k + 50);
        prescale = PW'(7);
        data_in  = 8'h0F;
        wait_idle(800);
        repeat (5) @(negedge clk);

        // Reset wins over a simultaneous request.
        reset   = 1'b1;
        cs      = 1'b1;
        start   = 1'b1;
        data_in = 8'h81;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        repeat (40) @(negedge clk);

        summary_and_finish();
    end

endmodule
